// File: rtl/kf_pkg.sv
// Shared types, Q-format constants and fixed-point helpers for the
// sequential Kalman measurement-update engine.
package kf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INNOV,
    RECIP,
    GAIN,
    XUPD,
    PUPD,
    DONE
  } state_t;

  localparam int KF_W    = 16;
  localparam int KF_FRAC = 8;
  localparam int DIV_LAT = KF_W + KF_FRAC;
  localparam int ONE     = 1 << KF_FRAC;
  localparam int MAXV    = (1 << (KF_W - 1)) - 1;
  localparam int MINV    = -(1 << (KF_W - 1));

  // Clamp a wide signed value into a w-bit signed range.
  function automatic longint sat(input longint v, input int w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic longint qmul(input longint a, input longint b,
                                  input int frac, input int w);
    return sat((a * b) >>> frac, w);
  endfunction

endpackage

// File: rtl/kf_fx_recip.sv
// Restoring unsigned divider computing 2^(2*FRAC) / divisor, one quotient
// bit per cycle; done is high during the final iteration cycle.
module kf_fx_recip
  import kf_pkg::*;
#(
  parameter int W    = KF_W,
  parameter int FRAC = KF_FRAC,
  parameter int DL   = W + FRAC
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  divisor,
  output logic          done,
  output logic [DL-1:0] quot
);

  localparam int CW = (DL > 1) ? $clog2(DL) : 1;
  localparam logic [DL-1:0] DIVIDEND = DL'(64'd1 << (2 * FRAC));

  logic          busy_reg;
  logic [CW-1:0] cnt_reg;
  logic [W-1:0]  rem_reg;
  logic [W-1:0]  div_reg;
  logic [DL-1:0] q_reg;
  logic [W:0]    trial;
  logic [W:0]    diff;

  // The dividend is shifted out of q_reg as quotient bits shift in.
  always_comb begin
    trial = {rem_reg, q_reg[DL-1]};
    diff  = trial - {1'b0, div_reg};
    done  = busy_reg && (cnt_reg == CW'(DL - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg <= 1'b0;
      cnt_reg  <= '0;
      rem_reg  <= '0;
      div_reg  <= '0;
      q_reg    <= '0;
    end else if (start) begin
      busy_reg <= 1'b1;
      cnt_reg  <= '0;
      rem_reg  <= '0;
      div_reg  <= divisor;
      q_reg    <= DIVIDEND;
    end else if (busy_reg) begin
      q_reg   <= {q_reg[DL-2:0], ~diff[W]};
      rem_reg <= diff[W] ? trial[W-1:0] : diff[W-1:0];
      cnt_reg <= cnt_reg + 1'b1;
      if (done) busy_reg <= 1'b0;
    end
  end

  assign quot = q_reg;

endmodule

// File: rtl/kf_seq_meas_update.sv
// Sequential Kalman measurement update: N_MEAS scalar updates applied in turn
// through one shared multiplier and one reciprocal unit.
module kf_seq_meas_update
  import kf_pkg::*;
#(
  parameter int W       = KF_W,
  parameter int FRAC    = KF_FRAC,
  parameter int N_STATE = 6,
  parameter int N_MEAS  = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_STATE*W-1:0]         x_in,
  input  logic [N_STATE*N_STATE*W-1:0] p_in,
  input  logic [N_MEAS*W-1:0]          z_in,
  input  logic [N_MEAS*W-1:0]          r_in,
  output logic                         out_valid,
  output logic [N_STATE*W-1:0]         x_out,
  output logic [N_STATE*N_STATE*W-1:0] p_out,
  output logic [N_MEAS-1:0]            err_flags
);

  localparam int DL = W + FRAC;
  localparam int W2 = 2 * W;
  localparam int NP = N_STATE * N_STATE;
  localparam int IW = (N_STATE > 1) ? $clog2(N_STATE) : 1;
  localparam int JW = (N_MEAS > 1) ? $clog2(N_MEAS) : 1;
  localparam int PW = (NP > 1) ? $clog2(NP) : 1;
  localparam logic [DL-1:0] MAXQ = DL'((longint'(1) <<< (W - 1)) - 1);

  state_t state_reg, state_next;
  logic [JW-1:0] j_reg;
  logic [IW-1:0] i_reg, k_reg;

  logic signed [W-1:0] x_reg    [N_STATE];
  logic signed [W-1:0] p_reg    [NP];
  logic signed [W-1:0] gain_reg [N_STATE];
  logic signed [W-1:0] prow_reg [N_STATE];
  logic signed [W-1:0] z_reg    [N_MEAS];
  logic signed [W-1:0] r_reg    [N_MEAS];
  logic signed [W-1:0] y_reg;

  logic                         out_valid_reg;
  logic [N_MEAS-1:0]            err_reg;
  logic [N_STATE*W-1:0]         x_out_reg;
  logic [N_STATE*N_STATE*W-1:0] p_out_reg;

  logic [IW-1:0]        jx;
  logic [PW-1:0]        idx_jj, idx_ij, idx_ji, idx_ik;
  logic                 i_last, k_last, j_last;
  longint               y_full, s_full;
  logic                 s_pos;
  logic                 div_start, div_done;
  logic [DL-1:0]        quot;
  logic signed [W-1:0]  inv, mul_a, mul_b;
  logic signed [W2-1:0] prod, prod_sh;
  logic signed [W-1:0]  gain_wb, x_wb, p_wb;

  kf_fx_recip #(.W(W), .FRAC(FRAC), .DL(DL)) u_recip (
    .clk     (clk),
    .rst     (rst),
    .start   (div_start),
    .divisor (W'(s_full)),
    .done    (div_done),
    .quot    (quot)
  );

  always_comb begin
    jx     = IW'(j_reg);
    idx_jj = PW'(int'(j_reg) * N_STATE + int'(j_reg));
    idx_ij = PW'(int'(i_reg) * N_STATE + int'(j_reg));
    idx_ji = PW'(int'(j_reg) * N_STATE + int'(i_reg));
    idx_ik = PW'(int'(i_reg) * N_STATE + int'(k_reg));
    i_last = (i_reg == IW'(N_STATE - 1));
    k_last = (k_reg == IW'(N_STATE - 1));
    j_last = (j_reg == JW'(N_MEAS - 1));
    y_full = sat(longint'(z_reg[j_reg]) - longint'(x_reg[jx]), W);
    s_full = sat(longint'(p_reg[idx_jj]) + longint'(r_reg[j_reg]), W);
    s_pos  = (s_full > 0);
    inv    = (quot > MAXQ) ? W'(MAXQ) : quot[W-1:0];

    // Single multiplier, operands steered by phase.
    mul_a = '0;
    mul_b = '0;
    case (state_reg)
      GAIN: begin mul_a = p_reg[idx_ij];    mul_b = inv;             end
      XUPD: begin mul_a = gain_reg[i_reg];  mul_b = y_reg;           end
      PUPD: begin mul_a = gain_reg[i_reg];  mul_b = prow_reg[k_reg]; end
      default: ;
    endcase
    prod    = W2'(mul_a) * W2'(mul_b);
    prod_sh = prod >>> FRAC;
    gain_wb = W'(sat(longint'(prod_sh), W));
    x_wb    = W'(sat(longint'(x_reg[i_reg]) + longint'(prod_sh), W));
    p_wb    = W'(sat(longint'(p_reg[idx_ik]) - longint'(prod_sh), W));
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    div_start  = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = INNOV;
      end
      INNOV: begin
        if (s_pos) begin
          div_start  = 1'b1;
          state_next = RECIP;
        end else if (j_last) begin
          state_next = DONE;
        end
      end
      RECIP:   if (div_done) state_next = GAIN;
      GAIN:    if (i_last) state_next = XUPD;
      XUPD:    if (i_last) state_next = PUPD;
      PUPD:    if (i_last && k_last) state_next = j_last ? DONE : INNOV;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      j_reg         <= '0;
      i_reg         <= '0;
      k_reg         <= '0;
      y_reg         <= '0;
      out_valid_reg <= 1'b0;
      err_reg       <= '0;
      x_out_reg     <= '0;
      p_out_reg     <= '0;
      for (int n = 0; n < N_STATE; n++) begin
        x_reg[n]    <= '0;
        gain_reg[n] <= '0;
        prow_reg[n] <= '0;
      end
      for (int n = 0; n < NP; n++) p_reg[n] <= '0;
      for (int n = 0; n < N_MEAS; n++) begin
        z_reg[n] <= '0;
        r_reg[n] <= '0;
      end
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE, DONE: begin
          // Results publish one edge after DONE is entered, then hold.
          if (state_reg == DONE) begin
            out_valid_reg <= 1'b1;
            for (int n = 0; n < N_STATE; n++) x_out_reg[n*W +: W] <= x_reg[n];
            for (int n = 0; n < NP; n++) p_out_reg[n*W +: W] <= p_reg[n];
          end
          if (in_valid) begin
            for (int n = 0; n < N_STATE; n++) x_reg[n] <= x_in[n*W +: W];
            for (int n = 0; n < NP; n++) p_reg[n] <= p_in[n*W +: W];
            for (int n = 0; n < N_MEAS; n++) begin
              z_reg[n] <= z_in[n*W +: W];
              r_reg[n] <= r_in[n*W +: W];
            end
            err_reg       <= '0;
            out_valid_reg <= 1'b0;
            j_reg         <= '0;
            i_reg         <= '0;
            k_reg         <= '0;
          end
        end
        INNOV: begin
          y_reg <= W'(y_full);
          i_reg <= '0;
          k_reg <= '0;
          if (!s_pos) begin
            err_reg[j_reg] <= 1'b1;
            if (!j_last) j_reg <= j_reg + 1'b1;
          end
        end
        GAIN: begin
          gain_reg[i_reg] <= gain_wb;
          prow_reg[i_reg] <= p_reg[idx_ji];
          i_reg           <= i_last ? '0 : i_reg + 1'b1;
        end
        XUPD: begin
          x_reg[i_reg] <= x_wb;
          i_reg        <= i_last ? '0 : i_reg + 1'b1;
        end
        PUPD: begin
          p_reg[idx_ik] <= p_wb;
          if (k_last) begin
            k_reg <= '0;
            i_reg <= i_last ? '0 : i_reg + 1'b1;
            if (i_last && !j_last) j_reg <= j_reg + 1'b1;
          end else begin
            k_reg <= k_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign x_out     = x_out_reg;
  assign p_out     = p_out_reg;
  assign err_flags = err_reg;

endmodule

// File: tb/tb_kf_seq_meas_update.sv
// Scoreboard bench: a matrix-level reference model predicts each bundle's
// result and latency; a monitor compares whenever out_valid rises.
module tb_kf_seq_meas_update;

  localparam int W = 16, FRAC = 8, NS = 6, NM = 3, NP = NS * NS;
  localparam int BW = NP * W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [NS*W-1:0]   x_in = '0;
  logic [NP*W-1:0]   p_in = '0;
  logic [NM*W-1:0]   z_in = '0;
  logic [NM*W-1:0]   r_in = '0;
  logic              out_valid;
  logic [NS*W-1:0]   x_out;
  logic [NP*W-1:0]   p_out;
  logic [NM-1:0]     err_flags;

  kf_seq_meas_update #(.W(W), .FRAC(FRAC), .N_STATE(NS), .N_MEAS(NM)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .p_in(p_in), .z_in(z_in), .r_in(r_in),
    .out_valid(out_valid), .x_out(x_out), .p_out(p_out), .err_flags(err_flags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int bx[NS], bp[NP], bz[NM], br[NM];
  logic [NS*W-1:0] ex_q[$];
  logic [NP*W-1:0] ep_q[$];
  logic [NM-1:0]   ee_q[$];
  int              lat_q[$];
  int              acc_q[$];
  int errors = 0;
  int checks = 0;

  function automatic longint sat_m(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic chk(input string name, input logic [BW-1:0] got, input logic [BW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Reference: scalar Kalman updates on plain integer matrices.
  task automatic model(output logic [NS*W-1:0] ex, output logic [NP*W-1:0] ep,
                       output logic [NM-1:0] ee, output int lat);
    longint x[NS];
    longint p[NS][NS];
    longint kk[NS];
    longint pr[NS];
    longint y, s, inv;
    ee  = '0;
    lat = 1;
    for (int i = 0; i < NS; i++) x[i] = bx[i];
    for (int r = 0; r < NS; r++)
      for (int c = 0; c < NS; c++) p[r][c] = bp[r*NS+c];
    for (int j = 0; j < NM; j++) begin
      y = sat_m(longint'(bz[j]) - x[j]);
      s = sat_m(p[j][j] + longint'(br[j]));
      if (s <= 0) begin
        ee[j] = 1'b1;
        lat += 1;
        continue;
      end
      lat += 1 + (W + FRAC) + 2 * NS + NS * NS;
      inv = (longint'(1) << (2 * FRAC)) / s;
      if (inv > 32767) inv = 32767;
      for (int i = 0; i < NS; i++) begin
        kk[i] = sat_m((p[i][j] * inv) >>> FRAC);
        pr[i] = p[j][i];
      end
      for (int i = 0; i < NS; i++) x[i] = sat_m(x[i] + ((kk[i] * y) >>> FRAC));
      for (int i = 0; i < NS; i++)
        for (int k = 0; k < NS; k++) p[i][k] = sat_m(p[i][k] - ((kk[i] * pr[k]) >>> FRAC));
    end
    for (int i = 0; i < NS; i++) ex[i*W +: W] = W'(x[i]);
    for (int r = 0; r < NS; r++)
      for (int c = 0; c < NS; c++) ep[(r*NS+c)*W +: W] = W'(p[r][c]);
  endtask

  task automatic drive_bundle();
    for (int n = 0; n < NS; n++) x_in[n*W +: W] = W'(bx[n]);
    for (int n = 0; n < NP; n++) p_in[n*W +: W] = W'(bp[n]);
    for (int n = 0; n < NM; n++) begin
      z_in[n*W +: W] = W'(bz[n]);
      r_in[n*W +: W] = W'(br[n]);
    end
  endtask

  task automatic send();
    logic [NS*W-1:0] ex;
    logic [NP*W-1:0] ep;
    logic [NM-1:0]   ee;
    int              lat;
    model(ex, ep, ee, lat);
    @(negedge clk);
    drive_bundle();
    chk("accept_ready", BW'(in_ready), BW'(1));
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    ex_q.push_back(ex);
    ep_q.push_back(ep);
    ee_q.push_back(ee);
    lat_q.push_back(lat);
    acc_q.push_back(cyc);
    $display("issued bundle at cycle %0d: expect err=%b latency=%0d", cyc, ee, lat);
  endtask

  task automatic drop_expected();
    ex_q.delete(); ep_q.delete(); ee_q.delete(); lat_q.delete(); acc_q.delete();
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 3000 && ex_q.size() != 0; c++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (ex_q.size() != 0) begin
      errors++;
      $display("FAIL timeout: got %0d pending results want 0", ex_q.size());
      drop_expected();
    end
  endtask

  task automatic monitor();
    logic prev;
    int   lat;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (out_valid && !prev) begin
          if (ex_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got out_valid=1 want no result pending");
          end else begin
            lat = cyc - acc_q.pop_front();
            chk("x_out", BW'(x_out), BW'(ex_q.pop_front()));
            chk("p_out", p_out, ep_q.pop_front());
            chk("err_flags", BW'(err_flags), BW'(ee_q.pop_front()));
            chk("latency", BW'(lat), BW'(lat_q.pop_front()));
            $display("result at cycle %0d: err=%b latency=%0d x0=%0h", cyc, err_flags, lat, x_out[W-1:0]);
          end
        end
        prev = out_valid;
      end
    end
  endtask

  task automatic set_identity();
    for (int n = 0; n < NS; n++) bx[n] = 0;
    for (int n = 0; n < NP; n++) bp[n] = ((n % (NS + 1)) == 0) ? 256 : 0;
    for (int n = 0; n < NM; n++) begin
      bz[n] = 512;
      br[n] = 256;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, BW'(in_ready), BW'(1));
    chk({tag, "_out_valid"}, BW'(out_valid), BW'(0));
    chk({tag, "_x_out"}, BW'(x_out), BW'(0));
    chk({tag, "_p_out"}, p_out, BW'(0));
    chk({tag, "_err"}, BW'(err_flags), BW'(0));
  endtask

  initial begin
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Identity covariance
    set_identity();
    send();
    wait_idle();
    chk("t1_x0", BW'(x_out[15:0]), BW'(16'h0100));
    chk("t1_x3", BW'(x_out[63:48]), BW'(16'h0000));
    chk("t1_p00", BW'(p_out[15:0]), BW'(16'h0080));

    // Back-to-back accept while in DONE
    send();
    chk("b2b_drop", BW'(out_valid), BW'(0));
    wait_idle();

    // Skipped first measurement
    set_identity();
    bp[0] = 0;
    br[0] = 0;
    send();
    wait_idle();
    chk("t2_err", BW'(err_flags), BW'(3'b001));

    // Correlated states
    set_identity();
    bp[1] = 128;
    bp[NS] = 128;
    br[1] = 32767;
    br[2] = 32767;
    send();
    wait_idle();

    // Innovation saturation
    set_identity();
    bx[0] = 32512;
    bz[0] = -32512;
    send();
    wait_idle();
    chk("t4_x0", BW'(x_out[15:0]), BW'(16'h3F00));

    // Reset mid-run
    set_identity();
    send();
    repeat (99) @(negedge clk);
    drop_expected();
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    rst = 1'b0;

    // in_valid coinciding with reset must not be accepted
    @(negedge clk);
    drive_bundle();
    rst = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_wins_ready", BW'(in_ready), BW'(1));
    chk("rst_wins_valid", BW'(out_valid), BW'(0));

    // Fresh accept after reset reproduces the identity case
    set_identity();
    send();
    wait_idle();
    chk("t5_x0", BW'(x_out[15:0]), BW'(16'h0100));

    // Randomized bundles
    for (int t = 0; t < 8; t++) begin
      for (int n = 0; n < NS; n++) bx[n] = int'(shortint'($urandom));
      for (int r = 0; r < NS; r++) begin
        for (int c = r; c < NS; c++) begin
          int v;
          if (r == c) v = int'($urandom_range(0, 1024));
          else v = int'($urandom_range(0, 512)) - 256;
          bp[r*NS+c] = v;
          bp[c*NS+r] = v;
        end
      end
      for (int n = 0; n < NM; n++) begin
        bz[n] = (t % 2 == 0) ? int'(shortint'($urandom)) : bx[n] + int'($urandom_range(0, 1024)) - 512;
        br[n] = int'($urandom_range(0, 1536)) - 512;
      end
      send();
      wait_idle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
